// File: rtl/data_mem_responder.sv
// Handshaked data-port memory responder: one load/store in flight, held for LATENCY
// wait states, then a word access on an internal RAM with a registered response.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    // state | meaning
    // IDLE  | ready to accept a request
    // WAIT  | request latched, counting wait states down to 1
    // RESP  | response registered, waiting for rsp_ready_i

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY);
    localparam bit          NO_WAIT    = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          wait_done;
    logic          acc_fire;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [31:0]   acc_off;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic          mem_we;

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign wait_done   = (cnt_q <= 4'd1);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // With no wait states the access uses the incoming request on its acceptance edge.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_be    = req_be_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_off  = acc_addr - BASE_ADDR;
        acc_idx  = acc_off[AW+1:2];
        acc_err  = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_off} >= SPAN_BYTES);
        acc_fire = (accept && NO_WAIT) || ((state_q == WAIT) && wait_done);
        mem_we   = acc_fire && acc_we && !acc_err && rst_ni;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    cnt_d   = LAT_LOAD;
                    state_d = NO_WAIT ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_done) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (acc_fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? 32'h0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 0, 4) driven by directed
// and randomized transactions, checked against a plain word-array memory model.
module tb_data_mem_responder;

    localparam int N = 3;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n       [N];
    logic        req_valid   [N];
    logic        req_ready   [N];
    logic        req_we      [N];
    logic [31:0] req_addr    [N];
    logic [31:0] req_wdata   [N];
    logic [3:0]  req_be      [N];
    logic        rsp_valid   [N];
    logic        rsp_ready   [N];
    logic [31:0] rsp_rdata   [N];
    logic        rsp_err     [N];

    logic [31:0] model_mem [N][DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned LAT_G = (g == 0) ? 2 : (g == 1) ? 0 : 4;
        data_mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    (LAT_G),
            .BASE_ADDR  (BASE)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n[g]),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .req_we_i   (req_we[g]),
            .req_addr_i (req_addr[g]),
            .req_wdata_i(req_wdata[g]),
            .req_be_i   (req_be[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_ready_i(rsp_ready[g]),
            .rsp_rdata_o(rsp_rdata[g]),
            .rsp_err_o  (rsp_err[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_access(input int i, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rd, output bit err);
        logic [31:0] off;
        off = addr - BASE;
        err = (addr % 4 != 0) || (off >= DEPTH * 4);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[i][off / 4][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model_mem[i][off / 4];
            end
        end
    endtask

    // Called and returns at a negedge with instance i idle.
    task automatic do_txn(input int i, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          n;
        chk("ready_when_idle", req_ready[i], 1);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_be[i]    = be;
        rsp_ready[i] = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_access(i, we, addr, wdata, be, exp_rd, exp_err);
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
        req_be[i]    = 4'($urandom_range(0, 15));
        n = 1;
        while (!rsp_valid[i] && n < 40) begin
            chk("ready_while_wait", req_ready[i], 0);
            rsp_ready[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        got_rd  = rsp_rdata[i];
        got_err = rsp_err[i];
        if (!rsp_valid[i]) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("rsp_latency", n, lat_of(i) + 1);
        chk("rsp_rdata", rsp_rdata[i], exp_rd);
        chk("rsp_err", rsp_err[i], exp_err);
        chk("ready_in_resp", req_ready[i], 0);
        rsp_ready[i] = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid[i], 1);
            chk("hold_rdata", rsp_rdata[i], got_rd);
            chk("hold_err", rsp_err[i], got_err);
            chk("hold_ready", req_ready[i], 0);
        end
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        chk("rsp_done_valid", rsp_valid[i], 0);
        chk("rsp_done_ready", req_ready[i], 1);
        rsp_ready[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          acc;
        int          got;

        for (int i = 0; i < N; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'h0;
            req_wdata[i] = 32'h0;
            req_be[i]    = 4'h0;
            rsp_ready[i] = 1'b0;
        end
        #3;
        for (int i = 0; i < N; i++) begin
            chk("reset_rsp_valid", rsp_valid[i], 0);
            chk("reset_rsp_rdata", rsp_rdata[i], 0);
            chk("reset_rsp_err", rsp_err[i], 0);
            chk("reset_req_ready", req_ready[i], 1);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

        // basic store / load
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        chk("store_rdata_zero", rd, 0);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("load_deadbeef", rd, 32'hDEADBEEF);

        // byte enables
        do_txn(0, 1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
        do_txn(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, rd, er);
        do_txn(0, 1, 32'h20, 32'h55555555, 4'b0000, 0, rd, er);
        do_txn(0, 0, 32'h20, 32'h0, 4'hF, 0, rd, er);
        chk("load_byte_merge", rd, 32'h11BB33DD);

        // errors
        do_txn(0, 0, 32'h22, 32'h0, 4'hF, 0, rd, er);
        chk("misalign_err", er, 1);
        chk("misalign_rdata", rd, 0);
        do_txn(0, 1, BASE, 32'hCAFEF00D, 4'hF, 0, rd, er);
        do_txn(0, 1, BASE + DEPTH * 4, 32'h0BADF00D, 4'hF, 0, rd, er);
        chk("range_err", er, 1);
        do_txn(0, 0, BASE, 32'h0, 4'hF, 0, rd, er);
        chk("word0_unchanged", rd, 32'hCAFEF00D);

        // backpressure
        do_txn(0, 0, 32'h10, 32'h0, 4'hF, 5, rd, er);

        // LATENCY=0 back-to-back loads
        for (int w = 0; w < 3; w++)
            do_txn(1, 1, 32'(w * 4), $urandom, 4'hF, 0, rd, er);
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_be[1]    = 4'hF;
        acc = 0;
        got = 0;
        for (int k = 0; k < 7; k++) begin
            chk("b2b_valid", rsp_valid[1], 32'(k % 2));
            chk("b2b_ready", req_ready[1], 32'((k % 2) == 0));
            if (rsp_valid[1] && got < 3) begin
                chk("b2b_rdata", rsp_rdata[1], model_mem[1][got]);
                got++;
            end
            if (req_ready[1] && acc < 3) begin
                req_addr[1] = 32'(acc * 4);
                acc++;
            end else if (req_ready[1]) begin
                req_valid[1] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        chk("b2b_count", got, 3);

        // reset in the middle of a wait
        do_txn(2, 1, 32'h30, 32'h0, 4'hF, 0, rd, er);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h30;
        req_wdata[2] = 32'h12345678;
        req_be[2]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("midwait_busy", req_ready[2], 0);
        @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid[2], 0);
        chk("rst_req_ready", req_ready[2], 1);
        @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_valid", rsp_valid[2], 0);
        do_txn(2, 0, 32'h30, 32'h0, 4'hF, 0, rd, er);
        chk("dropped_store", rd, 0);

        // randomized traffic
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < DEPTH; w++)
                do_txn(i, 1, BASE + 32'(w * 4), $urandom, 4'hF, 0, rd, er);
            for (int t = 0; t < 60; t++) begin
                case ($urandom_range(0, 9))
                    0: a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
                    1: a = BASE + DEPTH * 4 + (32'($urandom_range(0, 255)) << 2);
                    2: a = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
                    default: a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
                endcase
                do_txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3), rd, er);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
